// File: rtl/gb_trace_pkg.sv
// gb_trace_pkg: shared types for the GameBoy CPU instruction-trace buffer
package gb_trace_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READOUT} trace_state_t;
    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  ir;
        logic [15:0] sp;
        logic [3:0]  flags;
    } cpu_snap_t;
    localparam int SNAP_W = 44;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: trace storage, synchronous write, asynchronous read, no reset
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 76
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    // one snapshot written per accepted retire
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular retire-trace capture with trigger and oldest-first readout
module cpu_trace_buffer
    import gb_trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int CYC_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      retire,
    input  logic [15:0]               pc,
    input  logic [7:0]                ir,
    input  logic [15:0]               sp,
    input  logic [3:0]                flags,
    input  logic                      arm,
    input  logic                      trig_pc_en,
    input  logic [15:0]               trig_pc,
    input  logic                      force_trig,
    input  logic                      rd_start,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [CYC_W+SNAP_W-1:0]   rd_data,
    output logic                      rd_last,
    output trace_state_t              state,
    output logic [$clog2(DEPTH):0]    count,
    output logic [CYC_W-1:0]          cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CYC_W + SNAP_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] POST_INIT = CW'(POST_TRIG);

    trace_state_t   state_q, state_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, start_ptr, raddr;
    logic [CW-1:0]  count_q, count_d, rem_q, rem_d, post_q, post_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic           rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [DW-1:0]  rd_data_q, rd_data_d, ram_rdata;
    logic           we, trig, hs;
    cpu_snap_t      snap;

    assign snap = '{pc: pc, ir: ir, sp: sp, flags: flags};

    // write qualification, trigger detect and readout addressing
    always_comb begin
        we = (state_q == ARMED || state_q == POST) && retire && !arm;
        trig = force_trig || (retire && trig_pc_en && pc == trig_pc);
        hs = rd_valid_q && rd_ready;
        start_ptr = (count_q == FULL) ? wptr_q : '0;
        raddr = (state_q == DONE) ? start_ptr : rptr_q;
        cycles_d = cycles_q + 1'b1;
    end

    trace_ram #(.DEPTH(DEPTH), .W(DW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata ({cycles_q, snap}),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // next-state: arm restarts capture anywhere but readout; rptr/rem track the beat after the one presented
    always_comb begin
        state_d = state_q;
        wptr_d = we ? wptr_q + 1'b1 : wptr_q;
        count_d = we ? ((count_q == FULL) ? FULL : count_q + 1'b1) : count_q;
        post_d = post_q;
        rptr_d = rptr_q;
        rem_d = rem_q;
        rd_valid_d = rd_valid_q;
        rd_last_d = rd_last_q;
        rd_data_d = rd_data_q;
        if (arm && state_q != READOUT) begin
            state_d = ARMED;
            wptr_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ARMED: if (trig) begin
                    post_d = POST_INIT;
                    state_d = (POST_TRIG == 0) ? DONE : POST;
                end
                POST: if (retire) begin
                    post_d = post_q - 1'b1;
                    state_d = (post_q == ONE) ? DONE : POST;
                end
                DONE: if (rd_start) begin
                    state_d = (count_q == '0) ? IDLE : READOUT;
                    rd_valid_d = (count_q != '0);
                    rd_data_d = ram_rdata;
                    rd_last_d = (count_q == ONE);
                    rptr_d = start_ptr + 1'b1;
                    rem_d = count_q - 1'b1;
                end
                READOUT: if (hs) begin
                    state_d = rd_last_q ? IDLE : READOUT;
                    rd_valid_d = !rd_last_q;
                    rd_data_d = rd_last_q ? rd_data_q : ram_rdata;
                    rd_last_d = !rd_last_q && (rem_q == ONE);
                    rptr_d = rptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // state and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
            rem_q <= '0;
            post_q <= '0;
            cycles_q <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
            rem_q <= rem_d;
            post_q <= post_d;
            cycles_q <= cycles_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q <= rd_last_d;
            rd_data_q <= rd_data_d;
        end
    end

    // post-trigger depth must leave at least one pre-trigger slot
    always_ff @(posedge clk) begin
        assert (POST_TRIG < DEPTH) else $error("POST_TRIG must be below DEPTH");
    end

    assign state = state_q;
    assign count = count_q;
    assign cycles = cycles_q;
    assign rd_valid = rd_valid_q;
    assign rd_last = rd_last_q;
    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scenario checks for the retire-trace buffer
module tb_cpu_trace_buffer;
    import gb_trace_pkg::*;

    logic clk = 1'b0, rst = 1'b0, retire = 1'b0, arm = 1'b0, trig_pc_en = 1'b0;
    logic force_trig = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
    logic [15:0] pc = '0, sp = '0, trig_pc = '0;
    logic [7:0] ir = '0;
    logic [3:0] flags = '0;
    logic rd_valid, rd_last, rd_valid0, rd_last0;
    logic [75:0] rd_data, rd_data0;
    trace_state_t state, state0;
    logic [3:0] count, count0;
    logic [31:0] cycles, cycles0;
    int checks = 0, errors = 0;
    logic seen0 = 1'b0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(8), .POST_TRIG(3), .CYC_W(32)) u_dut (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .ir(ir), .sp(sp), .flags(flags),
        .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .count(count), .cycles(cycles)
    );

    cpu_trace_buffer #(.DEPTH(8), .POST_TRIG(0), .CYC_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .ir(ir), .sp(sp), .flags(flags),
        .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid0), .rd_data(rd_data0),
        .rd_last(rd_last0), .state(state0), .count(count0), .cycles(cycles0)
    );

    always @(negedge clk) if (rd_valid0 === 1'b1) seen0 = 1'b1;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_retire(input logic [15:0] p);
        retire = 1'b1; pc = p; ir = p[7:0]; sp = ~p; flags = p[3:0];
        tick;
        retire = 1'b0;
    endtask

    task pulse_arm;
        arm = 1'b1; tick; arm = 1'b0;
    endtask

    task pulse_force;
        force_trig = 1'b1; tick; force_trig = 1'b0;
    endtask

    task do_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        #10 rst = 1'b0;
    endtask

    task readout(input logic [15:0] first_pc, input int n, input int stall_beat);
        int beat, stall;
        logic [31:0] prev;
        logic [15:0] ep;
        logic [43:0] exp_snap;
        beat = 0; stall = 0; prev = '0;
        rd_ready = 1'b0; rd_start = 1'b1;
        tick;
        rd_start = 1'b0;
        checks++; if (state !== READOUT) begin errors++; $display("FAIL rd_state got %0d want %0d", state, READOUT); end
        for (int c = 0; c < 60 && beat < n; c++) begin
            ep = first_pc + 16'(beat);
            exp_snap = {ep, ep[7:0], ~ep, ep[3:0]};
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid beat %0d got %b want 1", beat, rd_valid); end
            checks++; if (rd_data[43:0] !== exp_snap) begin errors++; $display("FAIL rd_snap beat %0d got %h want %h", beat, rd_data[43:0], exp_snap); end
            checks++; if (rd_last !== (beat == n - 1)) begin errors++; $display("FAIL rd_last beat %0d got %b want %b", beat, rd_last, beat == n - 1); end
            if (beat > 0) begin
                checks++; if (rd_data[75:44] <= prev) begin errors++; $display("FAIL stamp beat %0d got %0d want > %0d", beat, rd_data[75:44], prev); end
            end
            if (beat == stall_beat - 1 && stall < 3) begin
                rd_ready = 1'b0; stall++;
            end else begin
                rd_ready = 1'b1; prev = rd_data[75:44]; beat++;
            end
            tick;
        end
        rd_ready = 1'b0;
        checks++; if (beat != n) begin errors++; $display("FAIL rd_beats got %0d want %0d", beat, n); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_end got %b want 0", rd_valid); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rd_end_state got %0d want %0d", state, IDLE); end
        checks++; if (count !== 4'(n)) begin errors++; $display("FAIL rd_count got %0d want %0d", count, n); end
    endtask

    task test_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", state, IDLE); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
        checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", cycles); end
        #9 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cycles !== 32'd5) begin errors++; $display("FAIL cycles5 got %0d want 5", cycles); end
    endtask

    task capture_manual;
        pulse_arm;
        checks++; if (state !== ARMED) begin errors++; $display("FAIL arm_state got %0d want %0d", state, ARMED); end
        for (int i = 0; i < 4; i++) do_retire(16'h0100 + 16'(i));
        pulse_force;
        checks++; if (state !== POST || count !== 4'd4) begin errors++; $display("FAIL force_post got %0d/%0d want %0d/4", state, count, POST); end
        do_retire(16'h0104);
        do_retire(16'h0105);
        checks++; if (state !== POST) begin errors++; $display("FAIL post_hold got %0d want %0d", state, POST); end
        do_retire(16'h0106);
        checks++; if (state !== DONE || count !== 4'd7) begin errors++; $display("FAIL manual_done got %0d/%0d want %0d/7", state, count, DONE); end
    endtask

    task test_manual_trig;
        capture_manual;
        readout(16'h0100, 7, 0);
    endtask

    task test_backpressure;
        capture_manual;
        readout(16'h0100, 7, 3);
    endtask

    task test_pc_trigger;
        pulse_arm;
        trig_pc_en = 1'b1; trig_pc = 16'h0150;
        for (int i = 0; i < 20; i++) begin
            do_retire(16'h0140 + 16'(i));
            if (i == 15) begin
                checks++; if (state !== ARMED) begin errors++; $display("FAIL pre_trig got %0d want %0d", state, ARMED); end
            end
            if (i == 16) begin
                checks++; if (state !== POST) begin errors++; $display("FAIL pc_trig got %0d want %0d", state, POST); end
            end
        end
        checks++; if (state !== DONE || count !== 4'd8) begin errors++; $display("FAIL wrap_done got %0d/%0d want %0d/8", state, count, DONE); end
        do_retire(16'h0154);
        do_retire(16'h0155);
        trig_pc_en = 1'b0;
        checks++; if (state !== DONE || count !== 4'd8) begin errors++; $display("FAIL frozen got %0d/%0d want %0d/8", state, count, DONE); end
        readout(16'h014C, 8, 0);
    endtask

    task test_reset_post;
        pulse_arm;
        trig_pc_en = 1'b1; trig_pc = 16'h0150;
        for (int i = 0; i < 17; i++) do_retire(16'h0140 + 16'(i));
        trig_pc_en = 1'b0;
        checks++; if (state !== POST) begin errors++; $display("FAIL rp_post got %0d want %0d", state, POST); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== IDLE || count !== 4'd0) begin errors++; $display("FAIL rp_abort got %0d/%0d want %0d/0", state, count, IDLE); end
        #9 rst = 1'b0;
        for (int i = 0; i < 3; i++) do_retire(16'h0300 + 16'(i));
        checks++; if (state !== IDLE || count !== 4'd0) begin errors++; $display("FAIL rp_idle got %0d/%0d want %0d/0", state, count, IDLE); end
    endtask

    task test_edge;
        do_reset;
        arm = 1'b1; force_trig = 1'b1;
        tick;
        arm = 1'b0; force_trig = 1'b0;
        checks++; if (state !== ARMED) begin errors++; $display("FAIL arm_wins got %0d want %0d", state, ARMED); end
        checks++; if (state0 !== ARMED) begin errors++; $display("FAIL arm_wins0 got %0d want %0d", state0, ARMED); end
        pulse_force;
        checks++; if (state !== POST || count !== 4'd0) begin errors++; $display("FAIL edge_post got %0d/%0d want %0d/0", state, count, POST); end
        checks++; if (state0 !== DONE || count0 !== 4'd0) begin errors++; $display("FAIL p0_done got %0d/%0d want %0d/0", state0, count0, DONE); end
        for (int i = 0; i < 3; i++) do_retire(16'h0200 + 16'(i));
        checks++; if (state !== DONE || count !== 4'd3) begin errors++; $display("FAIL edge_done got %0d/%0d want %0d/3", state, count, DONE); end
        checks++; if (state0 !== DONE || count0 !== 4'd0) begin errors++; $display("FAIL p0_frozen got %0d/%0d want %0d/0", state0, count0, DONE); end
        seen0 = 1'b0;
        readout(16'h0200, 3, 0);
        checks++; if (state0 !== IDLE) begin errors++; $display("FAIL p0_idle got %0d want %0d", state0, IDLE); end
        checks++; if (seen0 !== 1'b0) begin errors++; $display("FAIL p0_rd_valid got %b want 0", seen0); end
    endtask

    initial begin
        test_reset;
        test_manual_trig;
        test_backpressure;
        test_pc_trigger;
        test_reset_post;
        test_edge;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
